// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache fills, D-cache fills and
// D-cache writebacks. One transaction at a time; each ends with a one-cycle REL
// state before new grants are considered.
//
// Optional feature: define MEM_ARB_RR_EN to round-robin between the two read
// requesters. Without it, I-cache reads always beat D-cache reads.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ic_rd_req/addr, ic_rd_valid  I-cache fill request / fill data valid
//   dc_rd_req/addr, dc_rd_valid  D-cache fill request / fill data valid
//   dc_wr_req/addr/line, dc_wr_done  D-cache writeback request / complete
//   mem_rd_req/addr, mem_data_valid  memory read port
//   mem_wr_req/addr/line, mem_wr_done  memory write port
//   busy, timeout_err            not idle / one-cycle watchdog pulse
module mem_arbiter #(
    parameter int unsigned ARCH_BITS        = 32,
    parameter int unsigned MEMORY_LINE_BITS = 128,
    parameter int unsigned TIMEOUT_CYCLES   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ic_rd_req,
    input  logic [ARCH_BITS-1:0]        ic_rd_addr,
    output logic                        ic_rd_valid,
    input  logic                        dc_rd_req,
    input  logic [ARCH_BITS-1:0]        dc_rd_addr,
    output logic                        dc_rd_valid,
    input  logic                        dc_wr_req,
    input  logic [ARCH_BITS-1:0]        dc_wr_addr,
    input  logic [MEMORY_LINE_BITS-1:0] dc_wr_line,
    output logic                        dc_wr_done,
    output logic                        mem_rd_req,
    output logic [ARCH_BITS-1:0]        mem_rd_addr,
    input  logic                        mem_data_valid,
    output logic                        mem_wr_req,
    output logic [ARCH_BITS-1:0]        mem_wr_addr,
    output logic [MEMORY_LINE_BITS-1:0] mem_wr_line,
    input  logic                        mem_wr_done,
    output logic                        busy,
    output logic                        timeout_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the timeout fires on the
    // edge that would take it to TIMEOUT_CYCLES.
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IC_RD,
        ST_DC_RD,
        ST_DC_WR,
        ST_REL
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ARCH_BITS-1:0]        rd_addr_q, rd_addr_d;
    logic [ARCH_BITS-1:0]        wr_addr_q, wr_addr_d;
    logic [MEMORY_LINE_BITS-1:0] wr_line_q, wr_line_d;
    logic                        mem_rd_req_q, mem_rd_req_d;
    logic                        mem_wr_req_q, mem_wr_req_d;
    logic                        busy_q, busy_d;
    logic                        timeout_err_q, timeout_err_d;
    logic                        ic_wins;
    logic                        cmpl;

`ifdef MEM_ARB_RR_EN
    // last_rd: 1 = D-cache was the most recent read grant.
    logic last_rd_q, last_rd_d;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        ic_wins = ic_rd_req && (!dc_rd_req || last_rd_q);
    end
`else
    always_comb begin
        ic_wins = ic_rd_req;
    end
`endif

    // Next-state, latch and watchdog logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_line_d     = wr_line_q;
        timeout_err_d = 1'b0;
        cmpl          = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_rd_d     = last_rd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dc_wr_req) begin
                    state_d   = ST_DC_WR;
                    wr_addr_d = dc_wr_addr;
                    wr_line_d = dc_wr_line;
                    cnt_d     = '0;
                end else if (ic_wins) begin
                    state_d   = ST_IC_RD;
                    rd_addr_d = ic_rd_addr;
                    cnt_d     = '0;
`ifdef MEM_ARB_RR_EN
                    last_rd_d = 1'b0;
`endif
                end else if (dc_rd_req) begin
                    state_d   = ST_DC_RD;
                    rd_addr_d = dc_rd_addr;
                    cnt_d     = '0;
`ifdef MEM_ARB_RR_EN
                    last_rd_d = 1'b1;
`endif
                end
            end
            ST_IC_RD, ST_DC_RD, ST_DC_WR: begin
                cmpl = (state_q == ST_DC_WR) ? mem_wr_done : mem_data_valid;
                // Completion takes priority over a coincident timeout.
                if (cmpl) begin
                    state_d = ST_REL;
                end else if (WDOG_EN && (cnt_q == CNT_W'(CNT_LAST))) begin
                    state_d       = ST_REL;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        mem_rd_req_d = (state_d == ST_IC_RD) || (state_d == ST_DC_RD);
        mem_wr_req_d = (state_d == ST_DC_WR);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_line_q     <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_rd_q     <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_line_q     <= wr_line_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
`ifdef MEM_ARB_RR_EN
            last_rd_q     <= last_rd_d;
`endif
        end
    end

    // Same-cycle completion strobes; suppressed while reset abandons the transfer.
    assign ic_rd_valid = !rst && (state_q == ST_IC_RD) && mem_data_valid;
    assign dc_rd_valid = !rst && (state_q == ST_DC_RD) && mem_data_valid;
    assign dc_wr_done  = !rst && (state_q == ST_DC_WR) && mem_wr_done;

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_line = wr_line_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A scoreboard queue holds
// the expected grant order (kind, address, line); a monitor pops and compares
// on each new memory request. Directed sequences cover latency, timeout,
// spurious strobes and mid-transaction reset.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;

    typedef struct {
        logic [1:0]    kind;   // 0 = IC read, 1 = DC read, 2 = DC write
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_rd_req = 1'b0;
    logic [AW-1:0] ic_rd_addr = '0;
    logic          ic_rd_valid;
    logic          dc_rd_req = 1'b0;
    logic [AW-1:0] dc_rd_addr = '0;
    logic          dc_rd_valid;
    logic          dc_wr_req = 1'b0;
    logic [AW-1:0] dc_wr_addr = '0;
    logic [LW-1:0] dc_wr_line = '0;
    logic          dc_wr_done;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_data_valid;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [LW-1:0] mem_wr_line;
    logic          mem_wr_done;
    logic          busy;
    logic          timeout_err;

    // Memory model: auto mode answers in the first request cycle; force_* are
    // directed overrides.
    logic auto_mem    = 1'b0;
    logic force_valid = 1'b0;
    logic force_done  = 1'b0;
    assign mem_data_valid = force_valid | (auto_mem & mem_rd_req);
    assign mem_wr_done    = force_done  | (auto_mem & mem_wr_req);

    logic [6:0] outs;
    assign outs = {ic_rd_valid, dc_rd_valid, dc_wr_done, mem_rd_req, mem_wr_req, busy, timeout_err};

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_popped = 0;
    logic sb_en    = 1'b0;
    txn_t sb_q[$];

    mem_arbiter #(
        .ARCH_BITS       (AW),
        .MEMORY_LINE_BITS(LW),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_rd_req     (ic_rd_req),
        .ic_rd_addr    (ic_rd_addr),
        .ic_rd_valid   (ic_rd_valid),
        .dc_rd_req     (dc_rd_req),
        .dc_rd_addr    (dc_rd_addr),
        .dc_rd_valid   (dc_rd_valid),
        .dc_wr_req     (dc_wr_req),
        .dc_wr_addr    (dc_wr_addr),
        .dc_wr_line    (dc_wr_line),
        .dc_wr_done    (dc_wr_done),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_data_valid(mem_data_valid),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_line   (mem_wr_line),
        .mem_wr_done   (mem_wr_done),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [AW-1:0] addr, input logic [LW-1:0] line);
        txn_t t;
        t.kind = kind;
        t.addr = addr;
        t.line = line;
        sb_q.push_back(t);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
        force_valid = 1'b0; force_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_outs", 128'(outs), 128'(0));
    endtask

    // Scoreboard monitor: a rising memory request starts a transaction.
    logic          rd_prev = 1'b0;
    logic          wr_prev = 1'b0;
    logic [1:0]    mon_kind;
    logic [AW-1:0] mon_addr;
    logic [LW-1:0] mon_line;
    txn_t          mon_exp;
    always @(negedge clk) begin
        if (sb_en && ((mem_rd_req && !rd_prev) || (mem_wr_req && !wr_prev))) begin
            mon_kind = mem_wr_req ? 2'd2 : ic_rd_valid ? 2'd0 : dc_rd_valid ? 2'd1 : 2'd3;
            mon_addr = mem_wr_req ? mem_wr_addr : mem_rd_addr;
            mon_line = mem_wr_req ? mem_wr_line : '0;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_txn", 128'(1), 128'(0));
            end else begin
                mon_exp = sb_q.pop_front();
                n_popped++;
                check("sb_kind", 128'(mon_kind), 128'(mon_exp.kind));
                check("sb_addr", 128'(mon_addr), 128'(mon_exp.addr));
                check("sb_line", mon_line, mon_exp.line);
            end
        end
        rd_prev = mem_rd_req;
        wr_prev = mem_wr_req;
    end

    // Drive served requesters low; returns when everything is dropped and idle.
    task automatic serve_until_idle(input string tag, input int rd_limit);
        int  rd_done = 0;
        bit  ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (dc_wr_done) dc_wr_req = 1'b0;
            if (ic_rd_valid || dc_rd_valid) rd_done++;
            if (rd_limit == 0) begin
                if (ic_rd_valid) ic_rd_req = 1'b0;
                if (dc_rd_valid) dc_rd_req = 1'b0;
            end else if (rd_done >= rd_limit) begin
                ic_rd_req = 1'b0;
                dc_rd_req = 1'b0;
            end
            if (!ic_rd_req && !dc_rd_req && !dc_wr_req && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 128'(ok), 128'(1));
    endtask

    int pulses;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Lone fetch with memory answering in cycle 3; address changes after grant.
        step();
        ic_rd_req = 1'b1; ic_rd_addr = 32'h1000;
        @(negedge clk);
        check("fetch_c0_rdreq", 128'(mem_rd_req), 128'(0));
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 2) ic_rd_addr = 32'h2000;
            if (c == 3) force_valid = 1'b1;
            @(negedge clk);
            check("fetch_rdreq", 128'(mem_rd_req), 128'(1));
            check("fetch_addr", 128'(mem_rd_addr), 128'(32'h1000));
            check("fetch_icvalid", 128'(ic_rd_valid), 128'(c == 3));
            check("fetch_dcvalid", 128'(dc_rd_valid), 128'(0));
        end
        step();
        force_valid = 1'b0; ic_rd_req = 1'b0;
        @(negedge clk);
        check("fetch_rel_busy", 128'(busy), 128'(1));
        check("fetch_rel_rdreq", 128'(mem_rd_req), 128'(0));
        step();
        @(negedge clk);
        check("fetch_idle_busy", 128'(busy), 128'(0));

        // Three-way contention: write, then IC read, then DC read.
        do_reset();
        auto_mem = 1'b1; sb_en = 1'b1;
        push(2'd2, 32'h8040, {16{8'hA5}});
        push(2'd0, 32'h0100, '0);
        push(2'd1, 32'h0200, '0);
        step();
        dc_wr_req = 1'b1; dc_wr_addr = 32'h8040; dc_wr_line = {16{8'hA5}};
        ic_rd_req = 1'b1; ic_rd_addr = 32'h0100;
        dc_rd_req = 1'b1; dc_rd_addr = 32'h0200;
        serve_until_idle("contend3_done", 0);
        check("contend3_sb_empty", 128'(sb_q.size()), 128'(0));

        // Repeated read contention over four transactions.
        do_reset();
`ifdef MEM_ARB_RR_EN
        push(2'd0, 32'h0100, '0); push(2'd1, 32'h0200, '0);
        push(2'd0, 32'h0100, '0); push(2'd1, 32'h0200, '0);
`else
        for (int i = 0; i < 4; i++) push(2'd0, 32'h0100, '0);
`endif
        step();
        ic_rd_req = 1'b1; ic_rd_addr = 32'h0100;
        dc_rd_req = 1'b1; dc_rd_addr = 32'h0200;
        serve_until_idle("rr_done", 4);
        check("rr_sb_empty", 128'(sb_q.size()), 128'(0));
        check("sb_total_txns", 128'(n_popped), 128'(7));
        sb_en = 1'b0; auto_mem = 1'b0;

        // Timeout: memory silent, request dropped right after grant.
        step();
        ic_rd_req = 1'b1; ic_rd_addr = 32'h3000;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) ic_rd_req = 1'b0;
            @(negedge clk);
            if (timeout_err) pulses++;
            check($sformatf("to_err_k%0d", k), 128'(timeout_err), 128'(k == 8));
            check($sformatf("to_rdreq_k%0d", k), 128'(mem_rd_req), 128'(k < 8));
            check("to_icvalid", 128'(ic_rd_valid), 128'(0));
            if (k == 8) check("to_rel_busy", 128'(busy), 128'(1));
            if (k == 9) check("to_idle_busy", 128'(busy), 128'(0));
        end
        check("to_pulse_count", 128'(pulses), 128'(1));

        // Spurious strobes while idle.
        step();
        force_valid = 1'b1; force_done = 1'b1;
        @(negedge clk);
        check("spur_idle_outs", 128'(outs), 128'(0));
        step();
        force_valid = 1'b0; force_done = 1'b0;
        @(negedge clk);
        check("spur_after_outs", 128'(outs), 128'(0));

        // Reset during DC_RD with a coincident valid.
        step();
        dc_rd_req = 1'b1; dc_rd_addr = 32'h4000;
        step();
        @(negedge clk);
        check("rstmid_rdreq", 128'(mem_rd_req), 128'(1));
        check("rstmid_addr", 128'(mem_rd_addr), 128'(32'h4000));
        step();
        rst = 1'b1; force_valid = 1'b1; dc_rd_req = 1'b0;
        @(negedge clk);
        check("rstmid_dcvalid", 128'(dc_rd_valid), 128'(0));
        step();
        rst = 1'b0; force_valid = 1'b0;
        @(negedge clk);
        check("rstmid_outs", 128'(outs), 128'(0));
        check("rstmid_addr_clr", 128'(mem_rd_addr), 128'(0));
        check("rstmid_line_clr", mem_wr_line, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
